// File: rtl/alsu_pkg.sv
// alsu_pkg
//   Definitions shared by the ALSU sequencer and the code around it:
//   the sequencer state encoding, the ALSU unit codes (select bits s3s2),
//   the carry-in source codes, and the default datapath and repeat widths.
package alsu_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned REP_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // ALSU unit, selected by s3s2
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_SHR   = 2'b10,
        UNIT_SHL   = 2'b11
    } unit_t;

    // Carry-in source for an operation
    typedef enum logic [1:0] {
        CIN_ZERO  = 2'b00,
        CIN_ONE   = 2'b01,
        CIN_CARRY = 2'b10,
        CIN_RSVD  = 2'b11
    } cin_mode_t;

    // The reserved carry-in code behaves like CIN_ZERO.
    function automatic logic cin_select(input cin_mode_t mode, input logic carry);
        logic cin;
        case (mode)
            CIN_ONE:   cin = 1'b1;
            CIN_CARRY: cin = carry;
            default:   cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/alsu_sequencer.sv
// alsu_sequencer
//   Sequential initiator for the 8-bit combinational ALSU. Owns the
//   accumulator, carry flag and sticky overflow flag. A command is taken over
//   a valid/ready handshake and either loads the accumulator (cmd_load) or
//   runs the selected ALSU operation cmd_rep+1 times on the accumulator, each
//   repetition feeding the updated acc and carry into the next. The result is
//   returned over a valid/ready response handshake. The ALSU itself sits
//   beside this block; its inputs are driven from registers here, so the path
//   ALSU in -> ALSU out -> acc is one full cycle.
//
// Ports
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   cmd_valid/ready command handshake; ready only while IDLE
//   cmd_sel         ALSU select {s3,s2,s1,s0}
//   cmd_b           B operand, or load value
//   cmd_cin_mode    carry-in source (0, 1, carry flag, reserved = 0)
//   cmd_load        load acc from cmd_b, no ALSU operation
//   cmd_rep         extra repetitions
//   alsu_a/b/s/cin  to the ALSU
//   alsu_f/cout/ovf from the ALSU
//   rsp_valid/ready response handshake
//   rsp_f/cout/ovf  final result, carry flag, sticky overflow
//   acc             accumulator
//   busy            sequencer is not IDLE
module alsu_sequencer
    import alsu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_cin_mode,
    input  logic             cmd_load,
    input  logic [REP_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] alsu_a,
    output logic [WIDTH-1:0] alsu_b,
    output logic [3:0]       alsu_s,
    output logic             alsu_cin,
    input  logic [WIDTH-1:0] alsu_f,
    input  logic             alsu_cout,
    input  logic             alsu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    state_t           state_q, state_d;

    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             ovf_q;
    logic [REP_W-1:0] cnt_q;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] b_q;
    cin_mode_t        mode_q;

    logic             accept;
    logic             exec_step;
    unit_t            unit;

    assign unit = unit_t'(sel_q[3:2]);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        exec_step = 1'b0;
        cmd_ready = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_load ? RESP : EXEC;
                end
            end

            EXEC: begin
                exec_step = 1'b1;
                // Counter holds the repetitions still owed after this one.
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, flags, latched command fields and repeat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= '0;
            b_q     <= '0;
            mode_q  <= CIN_ZERO;
        end else begin
            if (accept) begin
                sel_q  <= cmd_sel;
                b_q    <= cmd_b;
                mode_q <= cin_mode_t'(cmd_cin_mode);
                cnt_q  <= cmd_rep;
                ovf_q  <= 1'b0;
                // A load leaves the carry flag untouched.
                if (cmd_load) begin
                    acc_q <= cmd_b;
                end
            end

            if (exec_step) begin
                acc_q   <= alsu_f;
                // The logic unit has no meaningful carry; it clears the flag.
                carry_q <= (unit == UNIT_LOGIC) ? 1'b0 : alsu_cout;
                // ALSU overflow only means something for shift-left.
                if (unit == UNIT_SHL) begin
                    ovf_q <= ovf_q | alsu_ovf;
                end
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - REP_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything below is a register or a function of registers
    // ------------------------------------------------------------------
    assign alsu_a    = acc_q;
    assign alsu_b    = b_q;
    assign alsu_s    = sel_q;
    assign alsu_cin  = cin_select(mode_q, carry_q);

    assign rsp_valid = (state_q == RESP);
    assign rsp_f     = acc_q;
    assign rsp_cout  = carry_q;
    assign rsp_ovf   = ovf_q;

    assign acc       = acc_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alsu_sequencer.sv
module tb_alsu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_b;
    logic [1:0] cmd_cin_mode;
    logic       cmd_load;
    logic [2:0] cmd_rep;
    logic [7:0] alsu_a;
    logic [7:0] alsu_b;
    logic [3:0] alsu_s;
    logic       alsu_cin;
    logic [7:0] alsu_f;
    logic       alsu_cout;
    logic       alsu_ovf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_f;
    logic       rsp_cout;
    logic       rsp_ovf;
    logic [7:0] acc;
    logic       busy;

    alsu_sequencer #(.WIDTH(8), .REP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_b(cmd_b), .cmd_cin_mode(cmd_cin_mode),
        .cmd_load(cmd_load), .cmd_rep(cmd_rep),
        .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_s(alsu_s), .alsu_cin(alsu_cin),
        .alsu_f(alsu_f), .alsu_cout(alsu_cout), .alsu_ovf(alsu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .acc(acc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Combinational ALSU: returns {ovf, cout, f}. Arithmetic and logic units
    // also produce ovf/cout values so that the sequencer's masking is visible.
    function automatic logic [9:0] alsu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s, input logic cin);
        logic [8:0] t;
        logic [7:0] bb;
        logic [7:0] f;
        logic       co;
        logic       ov;
        case (s[3:2])
            2'b00: begin
                case (s[1:0])
                    2'b00:   bb = 8'h00;
                    2'b01:   bb = b;
                    2'b10:   bb = ~b;
                    default: bb = 8'hFF;
                endcase
                t  = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
                f  = t[7:0];
                co = t[8];
                ov = (a[7] == bb[7]) && (f[7] != a[7]);
            end
            2'b01: begin
                case (s[1:0])
                    2'b00:   f = a & b;
                    2'b01:   f = a | b;
                    2'b10:   f = a ^ b;
                    default: f = ~a;
                endcase
                co = ^a;
                ov = a[0];
            end
            2'b10: begin
                f  = {cin, a[7:1]};
                co = a[0];
                ov = a[7] ^ cin;
            end
            default: begin
                f  = {a[6:0], cin};
                co = a[7];
                ov = a[7] ^ a[6];
            end
        endcase
        return {ov, co, f};
    endfunction

    always_comb {alsu_ovf, alsu_cout, alsu_f} = alsu_ref(alsu_a, alsu_b, alsu_s, alsu_cin);

    // ------------------------------------------------------------------
    // Transaction-level model: on acceptance, run the whole command to
    // completion and remember the acc/carry trajectory and response time.
    // ------------------------------------------------------------------
    int         cyc = 0;
    bit         pending = 0;
    bit         m_load;
    int         t_acc;
    int         due;
    int         m_rep;
    logic [3:0] m_sel;
    logic [7:0] m_b;
    logic [1:0] m_mode;
    logic [7:0] m_acc = 8'h00;
    logic       m_carry = 1'b0;
    logic [7:0] fin_acc;
    logic       fin_carry;
    logic       fin_ovf;
    logic [7:0] traj [0:8];
    logic       ctraj[0:8];

    function automatic logic cin_of(input logic [1:0] mode, input logic carry);
        return (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? carry : 1'b0;
    endfunction

    always @(posedge clk) begin
        int c;
        logic [9:0] r;
        c = cyc + 1;
        if (!rst_n) begin
            pending = 0;
            m_acc   = 8'h00;
            m_carry = 1'b0;
        end else if (pending) begin
            if (cyc >= due && rsp_ready) begin
                pending = 0;
                m_acc   = fin_acc;
                m_carry = fin_carry;
            end
        end else if (cmd_valid) begin
            pending = 1;
            m_load  = cmd_load;
            t_acc   = c;
            m_sel   = cmd_sel;
            m_b     = cmd_b;
            m_mode  = cmd_cin_mode;
            m_rep   = int'(cmd_rep);
            fin_ovf = 1'b0;
            if (cmd_load) begin
                fin_acc   = cmd_b;
                fin_carry = m_carry;
                due       = c;
            end else begin
                traj[0]  = m_acc;
                ctraj[0] = m_carry;
                for (int k = 0; k <= m_rep; k++) begin
                    r           = alsu_ref(traj[k], m_b, m_sel, cin_of(m_mode, ctraj[k]));
                    traj[k+1]   = r[7:0];
                    ctraj[k+1]  = (m_sel[3:2] == 2'b01) ? 1'b0 : r[8];
                    if (m_sel[3:2] == 2'b11) fin_ovf = fin_ovf | r[9];
                end
                fin_acc   = traj[m_rep+1];
                fin_carry = ctraj[m_rep+1];
                due       = c + m_rep + 1;
            end
        end
        cyc = c;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [7:0] e_acc;
        int         idx;
        bit         in_exec;
        if (cyc > 0) begin
            in_exec = pending && !m_load && (cyc < due);
            idx     = cyc - t_acc;
            if (!pending)               e_acc = m_acc;
            else if (in_exec)           e_acc = traj[idx];
            else                        e_acc = fin_acc;
            chk("busy",      32'(busy),      32'(pending));
            chk("cmd_ready", 32'(cmd_ready), 32'(!pending));
            chk("rsp_valid", 32'(rsp_valid), 32'(pending && cyc >= due));
            chk("acc",       32'(acc),       32'(e_acc));
            chk("alsu_a",    32'(alsu_a),    32'(e_acc));
            if (pending && cyc >= due) begin
                chk("rsp_f",    32'(rsp_f),    32'(fin_acc));
                chk("rsp_cout", 32'(rsp_cout), 32'(fin_carry));
                chk("rsp_ovf",  32'(rsp_ovf),  32'(fin_ovf));
            end
            if (in_exec) begin
                chk("alsu_b",   32'(alsu_b),   32'(m_b));
                chk("alsu_s",   32'(alsu_s),   32'(m_sel));
                chk("alsu_cin", 32'(alsu_cin), 32'(cin_of(m_mode, ctraj[idx])));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    int         got_lat;
    logic [7:0] got_f;
    logic       got_cout;
    logic       got_ovf;

    task automatic issue(input logic [3:0] s, input logic [7:0] b, input logic [1:0] m,
                         input logic ld, input logic [2:0] r);
        int n;
        @(negedge clk);
        cmd_sel = s; cmd_b = b; cmd_cin_mode = m; cmd_load = ld; cmd_rep = r;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        got_lat = 1;
        while (!rsp_valid && got_lat < 40) begin
            @(negedge clk);
            got_lat++;
        end
        got_f    = rsp_f;
        got_cout = rsp_cout;
        got_ovf  = rsp_ovf;
    endtask

    task automatic respond();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_acc"},       32'(acc),       32'h00);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_f"},     32'(rsp_f),     32'h00);
        chk({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
        chk({tag, "_rsp_ovf"},   32'(rsp_ovf),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_sel = 4'h0; cmd_b = 8'h00;
        cmd_cin_mode = 2'b00; cmd_load = 1'b0; cmd_rep = 3'd0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("rst0");
        chk("rst0_alsu_a",   32'(alsu_a),   32'h00);
        chk("rst0_alsu_b",   32'(alsu_b),   32'h00);
        chk("rst0_alsu_s",   32'(alsu_s),   32'h0);
        chk("rst0_alsu_cin", 32'(alsu_cin), 32'd0);

        // Mid-stream reset while a load response is pending
        issue(4'h0, 8'h3C, 2'b00, 1'b1, 3'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("rst1");

        // Load 0x3C then add 5
        issue(4'h0, 8'h3C, 2'b00, 1'b1, 3'd0);
        chk("load3c_lat", 32'(got_lat), 32'd1);
        chk("load3c_f",   32'(got_f),   32'h3C);
        respond();
        issue(4'b0001, 8'h05, 2'b00, 1'b0, 3'd0);
        chk("add_lat",  32'(got_lat),  32'd2);
        chk("add_f",    32'(got_f),    32'h41);
        chk("add_cout", 32'(got_cout), 32'd0);
        chk("add_ovf",  32'(got_ovf),  32'd0);
        chk("add_acc",  32'(acc),      32'h41);
        respond();

        // Carry chain
        issue(4'h0, 8'hFF, 2'b00, 1'b1, 3'd0);
        respond();
        issue(4'b0001, 8'h01, 2'b00, 1'b0, 3'd0);
        chk("cc1_f",    32'(got_f),    32'h00);
        chk("cc1_cout", 32'(got_cout), 32'd1);
        respond();
        issue(4'b0001, 8'h00, 2'b10, 1'b0, 3'd0);
        chk("cc2_f",    32'(got_f),    32'h01);
        chk("cc2_cout", 32'(got_cout), 32'd0);
        respond();

        // Repeated shift-left with sticky overflow
        issue(4'h0, 8'h81, 2'b00, 1'b1, 3'd0);
        respond();
        issue(4'b1100, 8'h00, 2'b00, 1'b0, 3'd2);
        chk("shl_lat",  32'(got_lat),  32'd4);
        chk("shl_f",    32'(got_f),    32'h08);
        chk("shl_cout", 32'(got_cout), 32'd0);
        chk("shl_ovf",  32'(got_ovf),  32'd1);
        respond();

        // Backpressure with a competing command
        issue(4'b0001, 8'h03, 2'b00, 1'b0, 3'd1);
        cmd_sel = 4'h0; cmd_b = 8'h55; cmd_cin_mode = 2'b00; cmd_load = 1'b1; cmd_rep = 3'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_f",     32'(rsp_f),     32'(got_f));
            chk("bp_ready", 32'(cmd_ready), 32'd0);
        end
        respond();
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_new_valid", 32'(rsp_valid), 32'd1);
        chk("bp_new_f",     32'(rsp_f),     32'h55);
        respond();

        // Abort: reset lands on the 4th EXEC cycle of a rep=7 add
        issue(4'h0, 8'h10, 2'b00, 1'b1, 3'd0);
        respond();
        @(negedge clk);
        cmd_sel = 4'b0001; cmd_b = 8'h01; cmd_cin_mode = 2'b00; cmd_load = 1'b0; cmd_rep = 3'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cmd_valid    = ($urandom_range(0, 9) < 5);
            cmd_sel      = 4'($urandom);
            cmd_b        = 8'($urandom);
            cmd_cin_mode = 2'($urandom);
            cmd_load     = ($urandom_range(0, 3) == 0);
            cmd_rep      = 3'($urandom);
            rsp_ready    = ($urandom_range(0, 9) < 6);
            rst_n        = ($urandom_range(0, 99) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
